// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: sample buffer between the RVMYTH core output word and the
// avsddac D input. Core samples are queued and released to the DAC at a fixed
// cadence of one word every SAMPLE_DIV clocks. Playback starts only after the
// FIFO holds PRIME_LEVEL entries. On underrun the last word is held and the
// block re-primes. Writes arriving while the FIFO is full are dropped and flagged.
module dac_sample_fifo #(
    parameter int DW          = 10,
    parameter int DEPTH       = 16,
    parameter int SAMPLE_DIV  = 64,
    parameter int PRIME_LEVEL = 8,
    parameter int RESET_CODE  = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clr_flags,
    input  logic [DW-1:0]              din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [DW-1:0]              dac_d,
    output logic                       sample_tick,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   div;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic            full;
    logic            empty;
    logic            div_last;
    logic            push;
    logic            pop;
    logic            uf_evt;
    logic            ovf_evt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty     = (wr_ptr == rd_ptr);
    assign din_ready = !full;
    assign level     = wr_ptr - rd_ptr;
    assign div_last  = (div == CW'(SAMPLE_DIV - 1));

    // Decode this cycle's FIFO and flag events. Full is taken from the
    // registered pointers, so a same-cycle pop never opens room for a write.
    always_comb begin
        push    = din_valid && !full;
        ovf_evt = din_valid && full;
        pop     = 1'b0;
        uf_evt  = 1'b0;
        if (en && (state == RUN) && div_last) begin
            pop    = !empty;
            uf_evt = empty;
        end
    end

    // Sample storage. Data is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Write pointer advances on every accepted sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wr_ptr <= '0;
        else if (push)
            wr_ptr <= wr_ptr + 1'b1;
    end

    // Playback controller: divider, read pointer, DAC word and update strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div         <= '0;
            rd_ptr      <= '0;
            dac_d       <= DW'(RESET_CODE);
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= 1'b0;
            if (!en) begin
                state <= IDLE;
                div   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        div   <= '0;
                        state <= PRIME;
                    end
                    PRIME: begin
                        div <= '0;
                        if (level >= (AW+1)'(PRIME_LEVEL))
                            state <= RUN;
                    end
                    RUN: begin
                        if (div_last) begin
                            div <= '0;
                            if (pop) begin
                                dac_d       <= mem[rd_ptr[AW-1:0]];
                                rd_ptr      <= rd_ptr + 1'b1;
                                sample_tick <= 1'b1;
                            end else begin
                                state <= PRIME;
                            end
                        end else begin
                            div <= div + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        div   <= '0;
                    end
                endcase
            end
        end
    end

    // Sticky status flags; a new event in the same cycle beats clr_flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (uf_evt)
                underrun <= 1'b1;
            else if (clr_flags)
                underrun <= 1'b0;
            if (ovf_evt)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
        end
    end

endmodule
